// File: rtl/ilim_dac_pkg.sv
// Shared ILIM DAC link constants and FSM state encoding, used by both
// the transmit and receive ends of the serial link.
package ilim_dac_pkg;

    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FRAME_BITS = ADDR_W + DATA_W;
    localparam int unsigned NUM_CH     = 2 ** ADDR_W;
    localparam int unsigned CNT_W      = 4;

    localparam logic [DATA_W-1:0] RESET_CODE = 8'h80;
    localparam logic [CNT_W-1:0]  FRAME_CNT  = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    typedef enum logic {
        IDLE,
        SHIFT
    } rx_state_e;

endpackage

// File: rtl/ilim_dac_frame_rx_if.sv
// Serial frame input and decoded-frame status bundle of the ILIM DAC receiver.
interface ilim_dac_frame_rx_if;

    logic                             SPI_CS_N;
    logic                             SPI_SDI;
    logic                             FRAME_VALID;
    logic [ilim_dac_pkg::ADDR_W-1:0]  FRAME_ADDR;
    logic [ilim_dac_pkg::DATA_W-1:0]  FRAME_DATA;
    logic                             FRAME_ERR;
    logic                             BUSY;

    modport slave (
        input  SPI_CS_N,
        input  SPI_SDI,
        output FRAME_VALID,
        output FRAME_ADDR,
        output FRAME_DATA,
        output FRAME_ERR,
        output BUSY
    );

    modport master (
        output SPI_CS_N,
        output SPI_SDI,
        input  FRAME_VALID,
        input  FRAME_ADDR,
        input  FRAME_DATA,
        input  FRAME_ERR,
        input  BUSY
    );

endinterface

// File: rtl/ilim_shadow_regfile.sv
// Shadow copy of the DAC channel codes: one synchronous write port,
// one combinational read port, asynchronous reset to midscale.
module ilim_shadow_regfile
    import ilim_dac_pkg::*;
(
    input  logic              tx_clk,
    input  logic              OPB_RST,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [NUM_CH];

    always_ff @(posedge tx_clk or posedge OPB_RST) begin
        if (OPB_RST) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                mem_q[i] <= RESET_CODE;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ilim_dac_frame_rx.sv
// Receive end of the ILIM DAC serial link: frame capture and channel shadow.
// Optional error counter enabled by defining ILIM_RX_ERRCNT_EN.
module ilim_dac_frame_rx
    import ilim_dac_pkg::*;
(
    input  logic              tx_clk,
    input  logic              OPB_RST,
    ilim_dac_frame_rx_if.slave rx,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic [DATA_W-1:0] RD_DATA
`ifdef ILIM_RX_ERRCNT_EN
    ,
    output logic [7:0]        ERR_CNT,
    input  logic              ERR_CLR
`endif
);

    rx_state_e             state_q, state_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  armed_q;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]     frame_addr_q, frame_addr_d;
    logic [DATA_W-1:0]     frame_data_q, frame_data_d;
    logic                  shadow_we;

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        frame_addr_d  = frame_addr_q;
        frame_data_d  = frame_data_q;
        shadow_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Unarmed after reset: a frame already in flight is dropped silently.
                if (!rx.SPI_CS_N && armed_q) begin
                    sr_d      = {sr_q[FRAME_BITS-2:0], rx.SPI_SDI};
                    bit_cnt_d = CNT_W'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (!rx.SPI_CS_N) begin
                    sr_d = {sr_q[FRAME_BITS-2:0], rx.SPI_SDI};
                    if (bit_cnt_q != CNT_MAX) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                    if (bit_cnt_q == FRAME_CNT) begin
                        frame_valid_d = 1'b1;
                        frame_addr_d  = sr_q[FRAME_BITS-1 -: ADDR_W];
                        frame_data_d  = sr_q[DATA_W-1:0];
                        shadow_we     = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge tx_clk or posedge OPB_RST) begin
        if (OPB_RST) begin
            state_q       <= IDLE;
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            armed_q       <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_addr_q  <= '0;
            frame_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            armed_q       <= armed_q | rx.SPI_CS_N;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            frame_addr_q  <= frame_addr_d;
            frame_data_q  <= frame_data_d;
        end
    end

    ilim_shadow_regfile u_shadow (
        .tx_clk    (tx_clk),
        .OPB_RST   (OPB_RST),
        .wr_en_i   (shadow_we),
        .wr_addr_i (frame_addr_d),
        .wr_data_i (frame_data_d),
        .rd_addr_i (RD_ADDR),
        .rd_data_o (RD_DATA)
    );

    assign rx.FRAME_VALID = frame_valid_q;
    assign rx.FRAME_ERR   = frame_err_q;
    assign rx.FRAME_ADDR  = frame_addr_q;
    assign rx.FRAME_DATA  = frame_data_q;
    assign rx.BUSY        = (state_q == SHIFT);

`ifdef ILIM_RX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (ERR_CLR) begin
            err_cnt_d = '0;
        end else if (frame_err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge tx_clk or posedge OPB_RST) begin
        if (OPB_RST) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_ilim_dac_frame_rx.sv
// Directed bench for ilim_dac_frame_rx with a scoreboard of expected frame pulses.
module tb_ilim_dac_frame_rx;
    import ilim_dac_pkg::*;

    logic              tx_clk  = 1'b0;
    logic              OPB_RST = 1'b0;
    logic [ADDR_W-1:0] RD_ADDR = '0;
    logic [DATA_W-1:0] RD_DATA;
`ifdef ILIM_RX_ERRCNT_EN
    logic              ERR_CLR = 1'b0;
    logic [7:0]        ERR_CNT;
`endif

    ilim_dac_frame_rx_if rx_if ();

    ilim_dac_frame_rx dut (
        .tx_clk  (tx_clk),
        .OPB_RST (OPB_RST),
        .rx      (rx_if.slave),
        .RD_ADDR (RD_ADDR),
        .RD_DATA (RD_DATA)
`ifdef ILIM_RX_ERRCNT_EN
        ,
        .ERR_CNT (ERR_CNT),
        .ERR_CLR (ERR_CLR)
`endif
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        logic        valid;
        logic        err;
        logic [2:0]  addr;
        logic [7:0]  data;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_shadow [8];
    logic [2:0] last_addr;
    logic [7:0] last_data;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic reset_model();
        for (int i = 0; i < 8; i++) exp_shadow[i] = 8'h80;
        last_addr = '0;
        last_data = '0;
    endtask

    task automatic sweep(string tag);
        for (int a = 0; a < 8; a++) begin
            RD_ADDR = 3'(a);
            #1;
            check(tag, RD_DATA, exp_shadow[a]);
        end
    endtask

    // Shift n bits MSB first, then raise CS_N for the closing edge.
    task automatic send(int n, logic [16:0] bits, bit expect_pkt);
        logic [2:0] a;
        logic [7:0] d;
        bit         good;
        a    = bits[10:8];
        d    = bits[7:0];
        good = expect_pkt && (n == 11);
        for (int i = n - 1; i >= 0; i--) begin
            rx_if.SPI_CS_N = 1'b0;
            rx_if.SPI_SDI  = bits[i];
            tick();
            if (i == n - 1) check("busy_in_frame", rx_if.BUSY, 32'(expect_pkt));
        end
        rx_if.SPI_CS_N = 1'b1;
        rx_if.SPI_SDI  = 1'b0;
        if (good) begin
            sb.push_back('{valid: 1'b1, err: 1'b0, addr: a, data: d});
            RD_ADDR = a;
            #1;
            check("rd_old_before_edge", RD_DATA, exp_shadow[a]);
        end else if (expect_pkt) begin
            sb.push_back('{valid: 1'b0, err: 1'b1, addr: last_addr, data: last_data});
        end
        tick();
        check("pulse_valid", rx_if.FRAME_VALID, 32'(good));
        check("pulse_err", rx_if.FRAME_ERR, 32'(expect_pkt && !good));
        check("busy_after_frame", rx_if.BUSY, 0);
        if (good) begin
            exp_shadow[a] = d;
            last_addr     = a;
            last_data     = d;
            check("rd_new_after_edge", RD_DATA, d);
        end
    endtask

    always @(negedge tx_clk) begin
        if (!OPB_RST && (rx_if.FRAME_VALID || rx_if.FRAME_ERR)) begin
            check("sb_pulse_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("sb_valid", rx_if.FRAME_VALID, mon_e.valid);
                check("sb_err", rx_if.FRAME_ERR, mon_e.err);
                check("sb_addr", rx_if.FRAME_ADDR, mon_e.addr);
                check("sb_data", rx_if.FRAME_DATA, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_if.SPI_CS_N = 1'b1;
        rx_if.SPI_SDI  = 1'b0;
        reset_model();
        #1 OPB_RST = 1'b1;
        #2;
        check("rst_valid", rx_if.FRAME_VALID, 0);
        check("rst_err", rx_if.FRAME_ERR, 0);
        check("rst_addr", rx_if.FRAME_ADDR, 0);
        check("rst_data", rx_if.FRAME_DATA, 0);
        check("rst_busy", rx_if.BUSY, 0);
`ifdef ILIM_RX_ERRCNT_EN
        check("rst_errcnt", ERR_CNT, 0);
`endif
        tick();
        OPB_RST = 1'b0;
        tick();
        tick();
        sweep("t1_shadow_reset");

        // Test 2: addr 5, data A7
        send(11, 17'b101_1010_0111, 1'b1);
        check("t2_addr", rx_if.FRAME_ADDR, 5);
        check("t2_data", rx_if.FRAME_DATA, 8'hA7);
        tick();
        check("t2_valid_width", rx_if.FRAME_VALID, 0);
        sweep("t2_shadow");

        // Test 3: short, long and saturating frames
        send(10, 17'h2A5, 1'b1);
        send(12, 17'hABC, 1'b1);
`ifdef ILIM_RX_ERRCNT_EN
        check("t3_errcnt_2", ERR_CNT, 2);
`endif
        send(17, 17'h1FFFF, 1'b1);
        tick();
        check("t3_addr_held", rx_if.FRAME_ADDR, 5);
        check("t3_data_held", rx_if.FRAME_DATA, 8'hA7);
        sweep("t3_shadow");
`ifdef ILIM_RX_ERRCNT_EN
        check("t3_errcnt_3", ERR_CNT, 3);
        ERR_CLR = 1'b1;
        tick();
        check("t3_errcnt_clr", ERR_CNT, 0);
        send(3, 17'h5, 1'b1);
        check("t3_clr_wins", ERR_CNT, 0);
        ERR_CLR = 1'b0;
        send(5, 17'h15, 1'b1);
        check("t3_errcnt_after_clr", ERR_CNT, 1);
`endif

        // Test 4: back-to-back frames, one CS_N-high cycle between them
        send(11, {6'd0, 3'd0, 8'h01}, 1'b1);
        send(11, {6'd0, 3'd7, 8'hFE}, 1'b1);
        tick();
        sweep("t4_shadow");

        // Test 5: CS_N low through reset release, unarmed tail dropped
        OPB_RST        = 1'b1;
        rx_if.SPI_CS_N = 1'b0;
        reset_model();
        tick();
        OPB_RST = 1'b0;
        send(11, {6'd0, 3'd4, 8'h99}, 1'b0);
        send(11, {6'd0, 3'd2, 8'h3C}, 1'b1);
        tick();
        sweep("t5_shadow");

        // Test 6: reset pulse at bit 6 of a frame
        for (int i = 0; i < 6; i++) begin
            rx_if.SPI_CS_N = 1'b0;
            rx_if.SPI_SDI  = 1'(i & 1);
            tick();
        end
        check("t6_busy_mid", rx_if.BUSY, 1);
        #2 OPB_RST = 1'b1;
        #1;
        check("t6_busy_rst", rx_if.BUSY, 0);
        check("t6_valid_rst", rx_if.FRAME_VALID, 0);
        check("t6_addr_rst", rx_if.FRAME_ADDR, 0);
        reset_model();
        sweep("t6_shadow_rst");
        rx_if.SPI_CS_N = 1'b1;
        tick();
        OPB_RST = 1'b0;
        tick();
        send(11, {6'd0, 3'd6, 8'h55}, 1'b1);
        tick();
        sweep("t6_shadow_after");

        tick();
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
